// File: rtl/rx_mod.sv
// rx_mod: baseband slicer for the tx_mod pulse-shaped link plus an optional PRBS9 BER checker.
// Latency: bit_out/bit_valid 1 cycle after the sampled input; BER counters 2 cycles after it.
// Backpressure: none; enable is a sample-valid and all state holds while it is low.
// Optional feature: define RX_BER_EN to compile in the PRBS9 checker, lock FSM and counters.
module rx_mod #(
    parameter int N_OS       = 4,
    parameter int LOCK_CNT   = 32,
    parameter int UNLOCK_CNT = 8,
    parameter int CNT_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic signed [10:0]      rx_in,
    input  logic [$clog2(N_OS)-1:0] phase,
    input  logic                    ber_clr,
    output logic                    bit_out,
    output logic                    bit_valid,
    output logic                    locked,
    output logic [CNT_W-1:0]        bit_count,
    output logic [CNT_W-1:0]        err_count
);

    localparam int PW = $clog2(N_OS);

    logic [PW-1:0] cnt_q;
    logic          bit_out_q;
    logic          bit_valid_q;

    // Phase counter wraps naturally because N_OS is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Slicer: take the sign of the sample on the selected phase; bit_out holds between strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
        end else if (enable && (cnt_q == phase)) begin
            bit_out_q   <= ~rx_in[10];
            bit_valid_q <= 1'b1;
        end else begin
            bit_valid_q <= 1'b0;
        end
    end

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;

`ifdef RX_BER_EN

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [8:0]       h_q, h_d;
    logic [3:0]       fill_q, fill_d;
    logic [MW-1:0]    match_q, match_d;
    logic [UW-1:0]    miss_q, miss_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             pred;
    logic             unused_in;

    // PRBS9 x^9 + x^5 + 1 with h[0] newest.
    assign pred = h_q[8] ^ h_q[4];

    // Checker registers; everything returns to FILL with an empty history on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_FILL;
            h_q       <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            miss_q    <= '0;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            bit_cnt_q <= bit_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Lock FSM and counter next-state; only recovered-bit strobes move it.
    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        fill_d    = fill_q;
        match_d   = match_q;
        miss_d    = miss_q;
        bit_cnt_d = bit_cnt_q;
        err_cnt_d = err_cnt_q;

        if (bit_valid_q) begin
            unique case (state_q)
                ST_FILL: begin
                    h_d = {h_q[7:0], bit_out_q};
                    if (fill_q == 4'd8) begin
                        fill_d  = '0;
                        match_d = '0;
                        state_d = ST_SEARCH;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                ST_SEARCH: begin
                    h_d = {h_q[7:0], bit_out_q};
                    if (bit_out_q == pred) begin
                        if (match_q == MW'(LOCK_CNT - 1)) begin
                            match_d = '0;
                            miss_d  = '0;
                            state_d = ST_LOCKED;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel on our own prediction so channel errors don't corrupt the history.
                    h_d = {h_q[7:0], pred};
                    if (bit_cnt_q != '1) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    if (bit_out_q != pred) begin
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        if (miss_q == UW'(UNLOCK_CNT - 1)) begin
                            miss_d  = '0;
                            fill_d  = '0;
                            state_d = ST_FILL;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: begin
                    state_d = ST_FILL;
                    fill_d  = '0;
                end
            endcase
        end

        // Clear wins over any increment in the same cycle.
        if (ber_clr) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
        end
    end

    assign locked    = (state_q == ST_LOCKED);
    assign bit_count = bit_cnt_q;
    assign err_count = err_cnt_q;
    assign unused_in = ^rx_in[9:0];

`else

    logic unused_in;

    assign locked    = 1'b0;
    assign bit_count = '0;
    assign err_count = '0;
    assign unused_in = ^{rx_in[9:0], ber_clr};

`endif

endmodule

// File: tb/tb_rx_mod.sv
// tb_rx_mod: directed bench for rx_mod slicer, enable gating and (when built in) the PRBS9 checker.
// Latency: checks sampled on the falling edge, half a cycle after the updating rising edge.
// Backpressure: none; the bench drives enable directly.
module tb_rx_mod;

`ifdef RX_BER_EN
    localparam bit BER = 1'b1;
`else
    localparam bit BER = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic               enable;
    logic signed [10:0] rx_in;
    logic [1:0]         phase;
    logic               ber_clr;
    logic               bit_out;
    logic               bit_valid;
    logic               locked;
    logic [31:0]        bit_count;
    logic [31:0]        err_count;

    int total  = 0;
    int failed = 0;
    logic [8:0] gen;

    rx_mod #(.N_OS(4), .LOCK_CNT(32), .UNLOCK_CNT(8), .CNT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .rx_in     (rx_in),
        .phase     (phase),
        .ber_clr   (ber_clr),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .locked    (locked),
        .bit_count (bit_count),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Next PRBS9 bit: s[n] = s[n-9] ^ s[n-5], history newest in bit 0.
    task automatic next_prbs(output logic b);
        b   = gen[8] ^ gen[4];
        gen = {gen[7:0], b};
    endtask

    // One symbol = 4 identical samples; phase counter is aligned so cnt runs 0..3 per symbol.
    task automatic send_sym(input logic b);
        repeat (4) begin
            rx_in = b ? 11'sd100 : -11'sd100;
            @(negedge clk);
        end
    endtask

    task automatic send_prbs(input int n, input logic invert);
        logic b;
        for (int i = 0; i < n; i++) begin
            next_prbs(b);
            send_sym(b ^ invert);
        end
    endtask

    initial begin
        int strobes;
        rst     = 1'b0;
        enable  = 1'b0;
        rx_in   = 11'sd100;
        phase   = 2'd2;
        ber_clr = 1'b0;
        gen     = 9'h1FF;

        repeat (2) @(negedge clk);
        check("rst_bit_out",   {31'd0, bit_out},   32'd0);
        check("rst_bit_valid", {31'd0, bit_valid}, 32'd0);
        check("rst_locked",    {31'd0, locked},    32'd0);
        check("rst_bit_count", bit_count,          32'd0);
        check("rst_err_count", err_count,          32'd0);

        // Constant positive input: strobe after edges 3, 7, 11 following release.
        rst    = 1'b1;
        enable = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            check($sformatf("pos_valid_%0d", n), {31'd0, bit_valid}, {31'd0, (n % 4) == 3});
            if (bit_valid) check($sformatf("pos_bit_%0d", n), {31'd0, bit_out}, 32'd1);
        end

        // Negative input: next strobe slices to 0, exactly one strobe per 4 cycles.
        rx_in   = -11'sd100;
        strobes = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (bit_valid) begin
                strobes++;
                check("neg_bit", {31'd0, bit_out}, 32'd0);
            end
        end
        check("neg_strobes", strobes, 32'd1);

        // Enable toggled every cycle halves the rate: 4 strobes in 32 cycles.
        strobes = 0;
        for (int n = 0; n < 32; n++) begin
            enable = (n % 2) == 0;
            @(negedge clk);
            if (bit_valid) strobes++;
        end
        check("half_rate_strobes", strobes, 32'd4);
        check("half_rate_bit", {31'd0, bit_out}, 32'd0);
        enable = 1'b1;

        // Fresh reset so symbol boundaries line up with cnt == 0.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        gen = 9'h1FF;

        send_prbs(40, 1'b0);
        check("lock_not_yet", {31'd0, locked}, 32'd0);
        send_prbs(1, 1'b0);
        check("lock_41", {31'd0, locked}, {31'd0, BER});
        check("lock_bc0", bit_count, 32'd0);
        send_prbs(10, 1'b0);
        check("locked_bc10", bit_count, BER ? 32'd10 : 32'd0);
        check("locked_ec0",  err_count, 32'd0);

        // Single inverted symbol: one error, lock held.
        send_prbs(1, 1'b1);
        send_prbs(3, 1'b0);
        check("single_err_ec", err_count, BER ? 32'd1 : 32'd0);
        check("single_err_bc", bit_count, BER ? 32'd14 : 32'd0);
        check("single_err_lock", {31'd0, locked}, {31'd0, BER});

        // Corrupted stream: lock survives 7 misses, drops on the 8th.
        send_prbs(7, 1'b1);
        check("miss7_lock", {31'd0, locked}, {31'd0, BER});
        check("miss7_ec", err_count, BER ? 32'd8 : 32'd0);
        send_prbs(1, 1'b1);
        check("miss8_lock", {31'd0, locked}, 32'd0);
        check("miss8_ec", err_count, BER ? 32'd9 : 32'd0);
        check("miss8_bc", bit_count, BER ? 32'd22 : 32'd0);
        send_prbs(2, 1'b0);
        check("retain_bc", bit_count, BER ? 32'd22 : 32'd0);
        check("retain_ec", err_count, BER ? 32'd9 : 32'd0);

        // Restored stream relocks after 9 fill + 32 matches.
        send_prbs(41, 1'b0);
        check("relock", {31'd0, locked}, {31'd0, BER});

        // Clear pulse zeroes both counters on the next edge.
        ber_clr = 1'b1;
        @(negedge clk);
        ber_clr = 1'b0;
        check("clr_bc", bit_count, 32'd0);
        check("clr_ec", err_count, 32'd0);

        // Asynchronous reset mid-cycle while locked.
        send_prbs(3, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_locked", {31'd0, locked},    32'd0);
        check("arst_valid",  {31'd0, bit_valid}, 32'd0);
        check("arst_bit",    {31'd0, bit_out},   32'd0);
        check("arst_bc",     bit_count,          32'd0);

        $display("%0d/%0d checks passed", total - failed, total);
        $finish;
    end

endmodule
